// File: rtl/agc_tp_pkg.sv
// Shared constants and the sequencer state type for the AGC time-pulse generator.
// The STEP_MCT state exists only when TPGEN_STEP_EN is defined.
package agc_tp_pkg;

  localparam int NUM_TP = 12;
  localparam int NUM_PH = 4;

  typedef enum logic [1:0] {
    RUN,
    HALT_PEND,
    HALTED
`ifdef TPGEN_STEP_EN
    ,
    STEP_MCT
`endif
  } tp_state_t;

endpackage

// File: rtl/agc_onehot_ring.sv
// One-hot rotator with advance enable and park-to-bit-0.
// q is a registered copy of the next pointer value, or zero when not shown.
module agc_onehot_ring #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             park,
  input  logic             show,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ptr;
  logic [WIDTH-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr;
    if (park) begin
      ptr_next = WIDTH'(1);
    end else if (en) begin
      ptr_next = {ptr[WIDTH-2:0], ptr[WIDTH-1]};
    end
  end

  // The pointer keeps its position while blanked, so the output can drop to zero without losing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= WIDTH'(1);
      q   <= '0;
    end else begin
      ptr <= ptr_next;
      q   <= show ? ptr_next : '0;
    end
  end

endmodule

// File: rtl/agc_timepulse_gen.sv
// AGC time-pulse generator: DIV clocks per phase, 4 phases per pulse, 12 pulses per MCT.
// Define TPGEN_STEP_EN to enable single-MCT stepping while halted.
module agc_timepulse_gen
  import agc_tp_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic              STOP,
  input  logic              STEP,
  output logic [NUM_TP-1:0] T,
  output logic [NUM_PH-1:0] P,
  output logic              MCT_END,
  output logic              RUNNING
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] DIV_PRE  = 8'(DIV - 2);

  tp_state_t  state;
  tp_state_t  state_next;
  logic [7:0] div_cnt;
  logic       active_next;
  logic       advance;
  logic       div_wrap;

`ifndef TPGEN_STEP_EN
  logic unused_step;
  assign unused_step = STEP;
`endif

  // MCT_END marks the last cycle of the MCT being shown, so halting decisions key off it.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (STOP) state_next = HALT_PEND;
      end
      HALT_PEND: begin
        if (MCT_END)    state_next = HALTED;
        else if (!STOP) state_next = RUN;
      end
      HALTED: begin
        if (!STOP) state_next = RUN;
`ifdef TPGEN_STEP_EN
        else if (STEP) state_next = STEP_MCT;
`endif
      end
`ifdef TPGEN_STEP_EN
      STEP_MCT: begin
        if (MCT_END) state_next = HALTED;
      end
`endif
      default: state_next = RUN;
    endcase
  end

  assign active_next = (state_next != HALTED);
  assign advance     = RUNNING && active_next;
  assign div_wrap    = (div_cnt == DIV_LAST);

  agc_onehot_ring #(.WIDTH(NUM_PH)) u_p_ring (
    .clk  (SIM_CLK),
    .rst  (SIM_RST),
    .en   (advance && div_wrap),
    .park (!active_next),
    .show (active_next),
    .q    (P)
  );

  agc_onehot_ring #(.WIDTH(NUM_TP)) u_t_ring (
    .clk  (SIM_CLK),
    .rst  (SIM_RST),
    .en   (advance && div_wrap && P[NUM_PH-1]),
    .park (!active_next),
    .show (active_next),
    .q    (T)
  );

  // Coming out of reset or halt shows position 0 first; advancing starts only once RUNNING is set.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state   <= RUN;
      div_cnt <= 8'd0;
      MCT_END <= 1'b0;
      RUNNING <= 1'b0;
    end else begin
      state   <= state_next;
      RUNNING <= active_next;
      if (advance) begin
        div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
      end else begin
        div_cnt <= 8'd0;
      end
      MCT_END <= advance && (div_cnt == DIV_PRE) && P[NUM_PH-1] && T[NUM_TP-1];
    end
  end

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Self-checking bench for agc_timepulse_gen: directed scenarios plus random STOP/STEP/reset,
// compared each cycle against a position-counter reference model.
module tb_agc_timepulse_gen;
  import agc_tp_pkg::*;

  localparam int DIV   = 4;
  localparam int MCT   = 48 * DIV;
  localparam int NEVER = 32'h3fffffff;
  localparam int M_RUN = 0, M_PEND = 1, M_HALTED = 2, M_STEP = 3;
`ifdef TPGEN_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic              SIM_CLK = 1'b0;
  logic              SIM_RST = 1'b1;
  logic              STOP = 1'b0;
  logic              STEP = 1'b0;
  logic [NUM_TP-1:0] T;
  logic [NUM_PH-1:0] P;
  logic              MCT_END;
  logic              RUNNING;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int run_cnt = 0;
  int end_cnt = 0;
  int m_mode = M_RUN;
  bit m_shown = 1'b0;
  int m_pos = 0;

  agc_timepulse_gen #(.DIV(DIV)) dut (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .STOP    (STOP),
    .STEP    (STEP),
    .T       (T),
    .P       (P),
    .MCT_END (MCT_END),
    .RUNNING (RUNNING)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, got, exp);
    end
  endtask

  // Reference: one position counter 0..MCT-1 within the MCT plus a mode and a shown flag.
  task automatic modelStep();
    bit end_now;
    int nxt;
    if (SIM_RST) begin
      m_mode  = M_RUN;
      m_shown = 1'b0;
      m_pos   = 0;
      return;
    end
    end_now = m_shown && (m_pos == MCT - 1);
    nxt = m_mode;
    case (m_mode)
      M_RUN:    if (STOP) nxt = M_PEND;
      M_PEND:   if (end_now) nxt = M_HALTED; else if (!STOP) nxt = M_RUN;
      M_HALTED: if (!STOP) nxt = M_RUN; else if (STEP && STEP_EN) nxt = M_STEP;
      M_STEP:   if (end_now) nxt = M_HALTED;
      default:  nxt = M_RUN;
    endcase
    if (nxt != M_HALTED) m_pos = m_shown ? (m_pos + 1) % MCT : 0;
    else m_pos = 0;
    m_shown = (nxt != M_HALTED);
    m_mode  = nxt;
  endtask

  task automatic tick();
    logic [11:0] exp_t;
    logic [3:0]  exp_p;
    @(posedge SIM_CLK);
    modelStep();
    #1;
    exp_t = '0;
    exp_p = '0;
    if (m_shown) begin
      exp_t[m_pos / (4 * DIV)] = 1'b1;
      exp_p[(m_pos / DIV) % 4] = 1'b1;
    end
    checkOutput("T", 32'(T), 32'(exp_t));
    checkOutput("P", 32'(P), 32'(exp_p));
    checkOutput("MCT_END", 32'(MCT_END), 32'(m_shown && (m_pos == MCT - 1)));
    checkOutput("RUNNING", 32'(RUNNING), 32'(m_shown));
    if (RUNNING) run_cnt++;
    if (MCT_END) end_cnt++;
    cycle++;
    @(negedge SIM_CLK);
  endtask

  task automatic resetDut();
    SIM_RST = 1'b1;
    STOP    = 1'b0;
    STEP    = 1'b0;
    tick();
    tick();
    SIM_RST = 1'b0;
  endtask

  // Cycle c is the c-th clock edge after reset release; inputs are set before that edge.
  task automatic applyStimulus(input int n, input int stop_on, input int stop_off,
                               input int step_at, input int step2_at, input int rst_at);
    run_cnt = 0;
    end_cnt = 0;
    cycle   = 0;
    for (int c = 0; c < n; c++) begin
      STOP    = (c >= stop_on) && (c < stop_off);
      STEP    = (c == step_at) || (c == step2_at);
      SIM_RST = (c == rst_at);
      tick();
    end
    SIM_RST = 1'b0;
    STEP    = 1'b0;
  endtask

  initial begin
    $display("[TB] start, DIV=%0d step_en=%0d", DIV, STEP_EN);

    resetDut();
    applyStimulus(193, NEVER, NEVER, NEVER, NEVER, NEVER);
    checkOutput("free_run_cycles", 32'(run_cnt), 32'd193);
    checkOutput("free_run_ends", 32'(end_cnt), 32'd1);

    resetDut();
    applyStimulus(292, 50, NEVER, NEVER, NEVER, NEVER);
    checkOutput("stop_run_cycles", 32'(run_cnt), 32'd192);
    checkOutput("stop_ends", 32'(end_cnt), 32'd1);

    resetDut();
    applyStimulus(700, 0, NEVER, 300, 360, NEVER);
    checkOutput("step_run_cycles", 32'(run_cnt), STEP_EN ? 32'd384 : 32'd192);
    checkOutput("step_ends", 32'(end_cnt), STEP_EN ? 32'd2 : 32'd1);

    resetDut();
    applyStimulus(401, 20, 100, NEVER, NEVER, NEVER);
    checkOutput("stop_pulse_run_cycles", 32'(run_cnt), 32'd401);
    checkOutput("stop_pulse_ends", 32'(end_cnt), 32'd2);

    resetDut();
    applyStimulus(300, NEVER, NEVER, NEVER, NEVER, 70);
    checkOutput("midreset_run_cycles", 32'(run_cnt), 32'd299);
    checkOutput("midreset_ends", 32'(end_cnt), 32'd1);

    resetDut();
    cycle = 0;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(119, 0) == 0) STOP = ~STOP;
      STEP    = ($urandom_range(29, 0) == 0);
      SIM_RST = ($urandom_range(899, 0) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
